// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard controller: mux select encodings,
// FSM states and the shadow destination-register entry.
package fwd_pkg;

  localparam int RD_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_ALU = 2'b10;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    LSTALL = 2'b01,
    HOLD   = 2'b10
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '0;

  // A stage can supply a value only if it really writes a non-x0 register.
  function automatic logic producer_ok(input shadow_t e);
    return e.valid && e.regwrite && (e.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding priority compare: the youngest matching producer wins.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic              ex_ok,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_ok,
  input  logic [REG_AW-1:0] mem_rd,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_REG;
    if (use_src) begin
      if (ex_ok && (ex_rd == src)) begin
        sel = FWD_ALU;
      end else if (mem_ok && (mem_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the five-stage pipeline.
// Define FWD_HAZARD_PERF_EN to add the load_stall_cnt performance counter.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_flush,
  input  logic              mem_hold,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_if_id,
`ifdef FWD_HAZARD_PERF_EN
  output logic [CNT_W-1:0]  load_stall_cnt,
`endif
  output logic              bubble_ex
);

  shadow_t ex_q, ex_d;
  shadow_t mem_q, mem_d;
  shadow_t wb_q, wb_d;

  state_e state_q, state_d;
  state_e prev_q, prev_d;
  state_e eff_state;

  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;
  logic [1:0] fwd_a_calc, fwd_b_calc;

  logic ex_ok, mem_ok;
  logic load_use, lu_stall, id_issue;

  fwd_select #(.REG_AW(REG_AW)) u_sel_a (
    .src     (id_rs1),
    .use_src (id_use_rs1),
    .ex_ok   (ex_ok),
    .ex_rd   (ex_q.rd),
    .mem_ok  (mem_ok),
    .mem_rd  (mem_q.rd),
    .sel     (fwd_a_calc)
  );

  fwd_select #(.REG_AW(REG_AW)) u_sel_b (
    .src     (id_rs2),
    .use_src (id_use_rs2),
    .ex_ok   (ex_ok),
    .ex_rd   (ex_q.rd),
    .mem_ok  (mem_ok),
    .mem_rd  (mem_q.rd),
    .sel     (fwd_b_calc)
  );

  always_comb begin
    ex_ok    = producer_ok(ex_q);
    mem_ok   = producer_ok(mem_q);
    load_use = id_valid && ex_ok && ex_q.memread &&
               ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                (id_use_rs2 && (id_rs2 == ex_q.rd)));
    // A flush kills the consumer, so a simultaneous load-use costs nothing.
    lu_stall    = load_use && !ex_flush;
    stall_if_id = mem_hold || lu_stall;
    bubble_ex   = !mem_hold && lu_stall;
    id_issue    = id_valid && !lu_stall && !ex_flush;
    eff_state   = (state_q == HOLD) ? prev_q : state_q;
  end

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    state_d = state_q;
    prev_d  = prev_q;
    if (mem_hold) begin
      state_d = HOLD;
      prev_d  = eff_state;
    end else begin
      state_d = (eff_state == RUN && lu_stall) ? LSTALL : RUN;
      prev_d  = RUN;
      wb_d    = mem_q;
      mem_d   = ex_q;
      if (id_issue) begin
        ex_d.valid    = 1'b1;
        ex_d.rd       = id_rd;
        ex_d.regwrite = id_regwrite;
        ex_d.memread  = id_memread;
        fwd_a_d       = fwd_a_calc;
        fwd_b_d       = fwd_b_calc;
      end else begin
        ex_d    = SHADOW_EMPTY;
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
      end
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!mem_hold && (eff_state == RUN) && lu_stall) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign load_stall_cnt = cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= SHADOW_EMPTY;
      mem_q   <= SHADOW_EMPTY;
      wb_q    <= SHADOW_EMPTY;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
      state_q <= RUN;
      prev_q  <= RUN;
`ifdef FWD_HAZARD_PERF_EN
      cnt_q   <= '0;
`endif
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      state_q <= state_d;
      prev_q  <= prev_d;
`ifdef FWD_HAZARD_PERF_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  // WB is tracked for completeness; the regfile write-before-read covers it.
  logic unused_shadow;
  assign unused_shadow = ^{wb_q, mem_q.memread};

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the 32-bit RISC-V five-stage pipeline. Keeps a shadow copy of the destination-register state for the EX, MEM and WB stages. From it, the block drives the 2-bit select inputs of the two EX-stage operand forwarding muxes, detects load-use hazards and generates the IF/ID stall and ID/EX bubble. It sits beside the ID/EX pipeline register and owns every forwarding-mux select in the core.

## Interface
- REG_AW, 5, register-address width
- CNT_W, 32, width of the load-stall counter (only used with the perf macro)

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REG_AW  ID source register addresses
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1 / rs2
- id_rd  in  REG_AW  ID destination register
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- ex_flush  in  1  taken branch/jump resolved in EX; kill the instruction in ID
- mem_hold  in  1  global pipeline freeze
- fwd_a_sel, fwd_b_sel  out  2  operand A/B mux select: 00 regfile, 01 WB data, 10 ALU (EX/MEM) result; 11 never driven
- stall_if_id  out  1  hold PC and the IF/ID register
- bubble_ex  out  1  load zero controls into ID/EX
- load_stall_cnt  out  CNT_W  load-use stall count (macro only)

## Operation
- Shadow pipeline: three entries EX, MEM, WB, each {valid, rd, regwrite, memread}.
- On each clock edge without mem_hold, the entries shift: ID→EX→MEM→WB.
- The ID entry is written into EX only if id_valid && !stall_if_id && !ex_flush; otherwise EX loads an invalid entry.
- A producer qualifies only if valid && regwrite && rd != 0. x0 is never forwarded and never causes a stall.
- Forward decision for each operand, computed in ID and registered into EX:
  - If the EX-shadow producer's rd matches the source, select 10. It will sit in EX/MEM when the consumer is in EX.
  - Else, if the MEM-shadow producer's rd matches, select 01.
  - Else, select 00. A WB-stage producer needs no forwarding because the regfile writes before it reads.
  - If the operand's id_use_* = 0, select 00.
- Load-use hazard: the EX shadow is a qualifying load, its rd matches a used source of a valid ID instruction, and ex_flush = 0. Response: stall_if_id = 1 and bubble_ex = 1 for exactly one cycle. The next cycle re-evaluates; the load is now in MEM and the operand selects 01.
- FSM states:
  - RUN: normal operation.
  - LSTALL: one cycle after a load-use detect. Always returns to RUN unless mem_hold is asserted.
  - HOLD: entered whenever mem_hold = 1. Shadow entries, selects and state are all frozen. stall_if_id = 1 and bubble_ex = 0. Returns to the frozen prior state when mem_hold falls.
- Priorities:
  - mem_hold beats ex_flush, which beats load-use.
  - If ex_flush and load-use occur in the same cycle, there is no stall. The ID instruction is dropped and the selects load 00.

## Timing
- stall_if_id and bubble_ex are combinational from the ID inputs and the shadow state, valid in the same cycle.
- fwd_*_sel are registered: they update on the edge where the instruction enters EX and are stable for its whole EX cycle.
- Load-use penalty is exactly 1 cycle. Back-to-back hazards each cost 1 cycle.
- Reset (asynchronous, any time, including during a stall): all shadow entries invalid, fwd_*_sel = 00, state RUN, stall_if_id = 0, bubble_ex = 0, load_stall_cnt = 0. The first edge after rst_n rises behaves as RUN with an empty pipeline.

## Configuration
- FWD_HAZARD_PERF_EN defined: load_stall_cnt increments by 1 on each edge leaving a load-use detect in RUN. It wraps modulo 2^CNT_W and is not incremented in HOLD.
- FWD_HAZARD_PERF_EN undefined: the counter and port are removed, and all other behaviour is identical.

## Structure
- Shared package fwd_pkg holds:
  - the select encodings: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_ALU = 2'b10
  - the FSM state enum {RUN, LSTALL, HOLD}
  - the shadow-entry struct
- One sub-module, fwd_select: a combinational per-operand priority compare, instantiated twice.

## Test plan
- add x5 (EX) followed by sub x6,x5,x7 in ID → next cycle fwd_a_sel = 10, fwd_b_sel = 00, no stall.
- add x5 followed by nop, then or x8,x1,x5 → fwd_b_sel = 01.
- lw x5 in EX with add x6,x5,x5 in ID → stall_if_id = 1 and bubble_ex = 1 for 1 cycle, then both selects = 01; with the macro, load_stall_cnt = 1.
- add x0,x1,x2 followed by add x3,x0,x0 → selects 00, no stall; lw x0 followed by a use of x0 → no stall.
- Load-use detected with ex_flush = 1 in the same cycle → no stall, next selects 00, shadow EX invalid. mem_hold held for 3 cycles mid-stall → outputs frozen, stall resumes and completes afterwards.
- rst_n pulsed low during LSTALL → selects 00 and stall 0 immediately; after release, an add followed by a dependent add forwards 10.
